// File: rtl/instr_mem_hs.sv
// Instruction memory with a valid/ready fetch handshake, configurable read latency,
// a runtime program-load write port and misaligned/out-of-range fault reporting.
module instr_mem_hs #(
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] FILL_WORD   = 32'h0000_0013,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic        rsp_err,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_data
);

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int          CW        = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [29:0] DEPTH_IDX = 30'(DEPTH_WORDS);
  localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 1) ? (LATENCY - 2) : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [31:0]   addr_q;
  logic [31:0]   rd_addr;
  logic          accept;
  logic          rd_en;
  logic          rd_fault;
  logic          prog_ok;
  logic          unused_ok;

  logic [31:0] mem [DEPTH_WORDS];

  // Power-up contents: every word is FILL_WORD.
  initial begin
    for (int i = 0; i < DEPTH_WORDS; i++) mem[i] = FILL_WORD;
  end

  assign req_ready = (state == IDLE) && !rst;
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;

  // With LATENCY==1 the array is read on the acceptance edge, before addr_q holds the address.
  assign rd_addr  = (state == IDLE) ? req_addr : addr_q;
  assign rd_fault = (rd_addr[1:0] != 2'b00) || (rd_addr[31:2] >= DEPTH_IDX);

  assign prog_ok   = prog_we && (prog_addr[31:2] < DEPTH_IDX);
  assign unused_ok = &{1'b0, prog_addr[1:0]};

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    rd_en   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
            rd_en   = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_d = RESP;
          rd_en   = 1'b1;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      rsp_instr <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (accept) addr_q <= req_addr;
      if (rd_en) begin
        rsp_err   <= rd_fault;
        rsp_instr <= rd_fault ? 32'h0 : mem[rd_addr[AW+1:2]];
      end
    end
  end

  // NOTE: the array is deliberately outside reset; contents survive rst and writes go on during it.
  always_ff @(posedge clk) begin
    if (prog_ok) mem[prog_addr[AW+1:2]] <= prog_data;
  end

endmodule

// File: tb/tb_instr_mem_hs.sv
// Directed bench for instr_mem_hs: three instances at LATENCY 1, 3 and 4 share clk and rst.
module tb_instr_mem_hs;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rq_v [3];
  logic        rdy  [3];
  logic [31:0] ra   [3];
  logic        rv   [3];
  logic        rs_r [3];
  logic [31:0] ri   [3];
  logic        re   [3];
  logic        pw   [3];
  logic [31:0] pa   [3];
  logic [31:0] pd   [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_mem_hs #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .req_valid(rq_v[0]), .req_ready(rdy[0]), .req_addr(ra[0]),
    .rsp_valid(rv[0]), .rsp_ready(rs_r[0]), .rsp_instr(ri[0]), .rsp_err(re[0]),
    .prog_we(pw[0]), .prog_addr(pa[0]), .prog_data(pd[0]));

  instr_mem_hs #(.DEPTH_WORDS(DEPTH), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .req_valid(rq_v[1]), .req_ready(rdy[1]), .req_addr(ra[1]),
    .rsp_valid(rv[1]), .rsp_ready(rs_r[1]), .rsp_instr(ri[1]), .rsp_err(re[1]),
    .prog_we(pw[1]), .prog_addr(pa[1]), .prog_data(pd[1]));

  instr_mem_hs #(.DEPTH_WORDS(DEPTH), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .req_valid(rq_v[2]), .req_ready(rdy[2]), .req_addr(ra[2]),
    .rsp_valid(rv[2]), .rsp_ready(rs_r[2]), .rsp_instr(ri[2]), .rsp_err(re[2]),
    .prog_we(pw[2]), .prog_addr(pa[2]), .prog_data(pd[2]));

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int d, input logic [31:0] addr, input logic [31:0] data);
    pw[d] = 1'b1; pa[d] = addr; pd[d] = data;
    tick();
    pw[d] = 1'b0;
  endtask

  // Issue one request with rsp_ready held high; ok=0 if no response within the budget.
  task automatic fetch(input int d, input logic [31:0] addr,
                       output logic [31:0] instr, output logic err, output bit ok);
    ok = 1'b0; instr = 'x; err = 1'bx;
    ra[d] = addr; rq_v[d] = 1'b1; rs_r[d] = 1'b1;
    tick();
    rq_v[d] = 1'b0;
    for (int i = 0; i < 16 && !ok; i++) begin
      if (rv[d]) begin
        instr = ri[d]; err = re[d]; ok = 1'b1;
      end else begin
        tick();
      end
    end
    tick();
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      rq_v[d] = 1'b0; ra[d] = '0; rs_r[d] = 1'b0; pw[d] = 1'b0; pa[d] = '0; pd[d] = '0;
    end
    rst = 1'b1;
    tick(); tick();
    for (int d = 0; d < 3; d++) begin
      checks++; if (rdy[d] !== 1'b0) begin errors++; $display("FAIL reset_rdy[%0d] got %b exp 0", d, rdy[d]); end
      checks++; if (rv[d] !== 1'b0) begin errors++; $display("FAIL reset_rv[%0d] got %b exp 0", d, rv[d]); end
    end
    checks++; if (ri[0] !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", ri[0]); end
    checks++; if (re[0] !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", re[0]); end
    rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++; if (rdy[d] !== 1'b1) begin errors++; $display("FAIL post_reset_rdy[%0d] got %b exp 1", d, rdy[d]); end
    end
  endtask

  task automatic test_fill();
    logic [31:0] ins; logic err; bit ok;
    fetch(0, 32'h20, ins, err, ok);
    checks++; if (!ok) begin errors++; $display("FAIL fill_timeout no rsp_valid"); end
    checks++; if (ins !== 32'h0000_0013) begin errors++; $display("FAIL fill_instr got %h exp 00000013", ins); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL fill_err got %b exp 0", err); end
  endtask

  task automatic test_program_l1();
    write_word(0, 32'h4, 32'h0050_0313);
    ra[0] = 32'h4; rq_v[0] = 1'b1; rs_r[0] = 1'b0;
    tick();
    rq_v[0] = 1'b0;
    checks++; if (rv[0] !== 1'b1) begin errors++; $display("FAIL l1_valid got %b exp 1", rv[0]); end
    checks++; if (ri[0] !== 32'h0050_0313) begin errors++; $display("FAIL l1_instr got %h exp 00500313", ri[0]); end
    checks++; if (re[0] !== 1'b0) begin errors++; $display("FAIL l1_err got %b exp 0", re[0]); end
    checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL l1_rdy_busy got %b exp 0", rdy[0]); end
    rs_r[0] = 1'b1;
    tick();
    checks++; if (rv[0] !== 1'b0) begin errors++; $display("FAIL l1_valid_drop got %b exp 0", rv[0]); end
    checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL l1_rdy_back got %b exp 1", rdy[0]); end
  endtask

  task automatic test_latency3();
    logic exp_rv [4];
    logic exp_rdy [4];
    exp_rv  = '{1'b0, 1'b0, 1'b1, 1'b0};
    exp_rdy = '{1'b0, 1'b0, 1'b0, 1'b1};
    ra[1] = 32'h8; rq_v[1] = 1'b1; rs_r[1] = 1'b1;
    tick();
    rq_v[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (rv[1] !== exp_rv[k]) begin errors++; $display("FAIL l3_valid T+%0d got %b exp %b", k + 1, rv[1], exp_rv[k]); end
      checks++; if (rdy[1] !== exp_rdy[k]) begin errors++; $display("FAIL l3_rdy T+%0d got %b exp %b", k + 1, rdy[1], exp_rdy[k]); end
      if (k == 2) begin
        checks++; if (ri[1] !== 32'h0000_0013) begin errors++; $display("FAIL l3_instr got %h exp 00000013", ri[1]); end
      end
      if (k < 3) tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ins; logic err; bit ok; bit seen;
    write_word(1, 32'h10, 32'h1111_1111);
    ra[1] = 32'h10; rq_v[1] = 1'b1; rs_r[1] = 1'b0;
    tick();
    rq_v[1] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      if (rv[1]) seen = 1'b1; else tick();
    end
    checks++; if (!seen) begin errors++; $display("FAIL bp_timeout no rsp_valid"); end
    for (int k = 0; k < 5; k++) begin
      if (k == 0) begin pw[1] = 1'b1; pa[1] = 32'h10; pd[1] = 32'hDEAD_BEEF; end
      tick();
      pw[1] = 1'b0;
      checks++; if (rv[1] !== 1'b1) begin errors++; $display("FAIL bp_valid hold %0d got %b exp 1", k, rv[1]); end
      checks++; if (ri[1] !== 32'h1111_1111) begin errors++; $display("FAIL bp_instr hold %0d got %h exp 11111111", k, ri[1]); end
    end
    rs_r[1] = 1'b1;
    tick();
    checks++; if (rv[1] !== 1'b0) begin errors++; $display("FAIL bp_release got %b exp 0", rv[1]); end
    fetch(1, 32'h10, ins, err, ok);
    checks++; if (!ok || ins !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bp_refetch got %h exp deadbeef", ins); end
    // A write to the pending word during WAIT is visible in the response.
    ra[1] = 32'h14; rq_v[1] = 1'b1; rs_r[1] = 1'b0;
    tick();
    rq_v[1] = 1'b0;
    write_word(1, 32'h14, 32'hCAFE_F00D);
    tick();
    checks++; if (rv[1] !== 1'b1 || ri[1] !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL wait_write got v=%b %h exp v=1 cafef00d", rv[1], ri[1]);
    end
    rs_r[1] = 1'b1;
    tick();
  endtask

  task automatic test_faults();
    logic [31:0] ins; logic err; bit ok;
    fetch(0, 32'h6, ins, err, ok);
    checks++; if (!ok || err !== 1'b1) begin errors++; $display("FAIL misalign_err got %b exp 1", err); end
    checks++; if (ins !== 32'h0) begin errors++; $display("FAIL misalign_instr got %h exp 0", ins); end
    fetch(0, 32'(4 * DEPTH), ins, err, ok);
    checks++; if (!ok || err !== 1'b1) begin errors++; $display("FAIL range_err got %b exp 1", err); end
    checks++; if (ins !== 32'h0) begin errors++; $display("FAIL range_instr got %h exp 0", ins); end
    write_word(0, 32'(4 * DEPTH), 32'h5555_5555);
    fetch(0, 32'h0, ins, err, ok);
    checks++; if (!ok || ins !== 32'h0000_0013 || err !== 1'b0) begin
      errors++; $display("FAIL oob_write word0 got %h err %b exp 00000013 err 0", ins, err);
    end
    write_word(0, 32'h1B, 32'h0000_ABCD);
    fetch(0, 32'h18, ins, err, ok);
    checks++; if (!ok || ins !== 32'h0000_ABCD) begin errors++; $display("FAIL low_bits_ignored got %h exp 0000abcd", ins); end
  endtask

  task automatic test_reset_wait();
    logic [31:0] ins; logic err; bit ok; bit rose;
    write_word(2, 32'h8, 32'h1234_5678);
    ra[2] = 32'h8; rq_v[2] = 1'b1; rs_r[2] = 1'b1;
    tick();
    rq_v[2] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    checks++; if (rdy[2] !== 1'b0) begin errors++; $display("FAIL rstwait_rdy_in_rst got %b exp 0", rdy[2]); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (rdy[2] !== 1'b1) begin errors++; $display("FAIL rstwait_rdy got %b exp 1", rdy[2]); end
    rose = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (rv[2] !== 1'b0) rose = 1'b1;
      tick();
    end
    checks++; if (rose) begin errors++; $display("FAIL rstwait_valid got 1 exp 0"); end
    fetch(2, 32'h8, ins, err, ok);
    checks++; if (!ok || ins !== 32'h1234_5678) begin errors++; $display("FAIL rstwait_retain got %h exp 12345678", ins); end
  endtask

  task automatic test_back_to_back();
    int acc;
    acc = 0;
    ra[0] = 32'h4; rq_v[0] = 1'b1; rs_r[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (rdy[0] === 1'b1) acc++;
      tick();
    end
    rq_v[0] = 1'b0;
    tick();
    checks++; if (acc !== 4) begin errors++; $display("FAIL b2b_accepts got %0d exp 4", acc); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_program_l1();
    test_latency3();
    test_backpressure();
    test_faults();
    test_reset_wait();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
